ring_counter_checker: RTL and testbench

Receive-side monitor for the one-hot ring counter. It samples the counter's one-hot output every clock and decodes it to a binary index. It checks one-hot validity and rotation order, locks onto a correctly rotating sequence, flags faults, and counts completed rotations. It sits beside any ring_counter instance as a self-check and status block.

---
 rtl/ring_pkg.sv | 40 ++++
 rtl/ring_counter_checker_if.sv | 35 +++
 rtl/onehot_decoder.sv | 28 ++
 rtl/ring_counter_checker.sv | 176 +++++++++++++++++
 tb/tb_ring_counter_checker.sv | 133 +++++++++++++
 5 files changed

// File: rtl/ring_pkg.sv
// Shared types and helpers for one-hot ring counter blocks.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
// Contents: state_e (checker FSM encoding), vec_t (widest supported ring),
//           rotl() one-position rotate-left, is_onehot() exactly-one-bit test.
package ring_pkg;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        LOCKED = 2'd1,
        FAULT  = 2'd2
    } state_e;

    // Helpers work on a fixed-width container so that any ring up to MAX_W
    // bits can use them; callers zero-extend on the way in and truncate on
    // the way out.
    localparam int MAX_W = 64;
    typedef logic [MAX_W-1:0] vec_t;

    // Rotate the low w bits of vec left by one; bit w-1 wraps to bit 0.
    // Bits at and above w are returned as zero.
    function automatic vec_t rotl(input vec_t vec, input int w);
        vec_t r;
        r = '0;
        for (int i = 0; i < MAX_W; i++) begin
            if (i == 0) begin
                r[0] = vec[w-1];
            end else if (i < w) begin
                r[i] = vec[i-1];
            end
        end
        return r;
    endfunction

    // True when exactly one bit is set (clearing the lowest set bit leaves 0).
    function automatic logic is_onehot(input vec_t vec);
        return (vec != '0) && ((vec & (vec - vec_t'(1))) == '0);
    endfunction

endpackage

// File: rtl/ring_counter_checker_if.sv
// Bus bundle between a ring counter monitor and its environment.
// Latency: n/a (wires only).
// Backpressure: none; the monitor observes every cycle.
// Signals: ring_in/clr driven by the master; index, valid, locked, fault,
//          err_onehot, err_seq, err_sticky, rot_count driven by the checker.
interface ring_counter_checker_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
);
    localparam int IW = $clog2(WIDTH);

    logic [WIDTH-1:0] ring_in;
    logic             clr;
    logic [IW-1:0]    index;
    logic             valid;
    logic             locked;
    logic             fault;
    logic             err_onehot;
    logic             err_seq;
    logic             err_sticky;
    logic [CNT_W-1:0] rot_count;

    modport master (
        output ring_in, clr,
        input  index, valid, locked, fault,
               err_onehot, err_seq, err_sticky, rot_count
    );

    modport slave (
        input  ring_in, clr,
        output index, valid, locked, fault,
               err_onehot, err_seq, err_sticky, rot_count
    );

endinterface

// File: rtl/onehot_decoder.sv
// One-hot validity check and binary encode of a WIDTH-bit vector.
// Latency: combinational.
// Backpressure: none.
// Ports: vec_i (input vector), oh_o (exactly one bit set), idx_o (position of
//        the set bit; meaningless when oh_o is low). WIDTH must be <= MAX_W.
module onehot_decoder
    import ring_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int IW    = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] vec_i,
    output logic             oh_o,
    output logic [IW-1:0]    idx_o
);

    always_comb begin
        oh_o  = is_onehot(vec_t'(vec_i));
        // OR-encoder: exact for one-hot input, cheap for everything else.
        idx_o = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (vec_i[i]) begin
                idx_o = idx_o | IW'(i);
            end
        end
    end

endmodule

// File: rtl/ring_counter_checker.sv
// Receive-side monitor for a one-hot ring counter: decode, lock, fault, count.
// Latency: 1 clk from ring_in sample to every output (all outputs registered).
// Backpressure: none; samples every clock, never stalls the ring.
// Ports: clk, rst (async active-high), bus (slave modport: ring_in, clr in;
//        index, valid, locked, fault, err_onehot, err_seq, err_sticky,
//        rot_count out).
module ring_counter_checker
    import ring_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int LOCK_CNT = 2,
    parameter int CNT_W    = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    ring_counter_checker_if.slave bus
);

    localparam int IW = $clog2(WIDTH);
    localparam int GW = $clog2(LOCK_CNT + 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e           state_q,      state_d;
    logic [GW-1:0]    good_q,       good_d;
    logic [WIDTH-1:0] prev_q,       prev_d;
    logic [IW-1:0]    index_q,      index_d;
    logic             valid_q,      valid_d;
    logic             locked_q;
    logic             fault_q;
    logic             err_oh_q,     err_oh_d;
    logic             err_seq_q,    err_seq_d;
    logic             sticky_q,     sticky_d;
    logic [CNT_W-1:0] rot_q,        rot_d;

    // ------------------------------------------------------------------
    // Sample classification
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] ring_s;
    logic [WIDTH-1:0] prev_rot;
    logic             oh_s;
    logic [IW-1:0]    idx_s;
    logic             adv;
    logic             stall;

    assign ring_s   = bus.ring_in;
    assign prev_rot = WIDTH'(rotl(vec_t'(prev_q), WIDTH));

    onehot_decoder #(
        .WIDTH (WIDTH),
        .IW    (IW)
    ) u_dec (
        .vec_i (ring_s),
        .oh_o  (oh_s),
        .idx_o (idx_s)
    );

    assign adv   = oh_s && (ring_s == prev_rot);
    // A repeated sample is a legitimately paused ring, never an error.
    assign stall = (ring_s == prev_q);

    // ------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        good_d    = good_q;
        prev_d    = ring_s;
        index_d   = index_q;
        valid_d   = oh_s;
        err_oh_d  = 1'b0;
        err_seq_d = 1'b0;
        sticky_d  = sticky_q;
        rot_d     = rot_q;

        if (oh_s) begin
            index_d = idx_s;
        end

        if (bus.clr) begin
            sticky_d = 1'b0;
            rot_d    = '0;
        end

        case (state_q)
            SEARCH: begin
                if (adv) begin
                    if (int'(good_q) + 1 == LOCK_CNT) begin
                        state_d = LOCKED;
                        good_d  = '0;
                    end else begin
                        good_d = good_q + 1'b1;
                    end
                end else if (!stall) begin
                    good_d = '0;
                end
            end

            LOCKED: begin
                if (adv) begin
                    // Landing on bit 0 completes a rotation; clr in the same
                    // cycle discards it, and the count sticks at all-ones.
                    if ((idx_s == '0) && !bus.clr && (rot_q != '1)) begin
                        rot_d = rot_q + 1'b1;
                    end
                end else if (!stall) begin
                    if (!oh_s) begin
                        err_oh_d = 1'b1;
                    end else begin
                        err_seq_d = 1'b1;
                    end
                    state_d = FAULT;
                end
            end

            FAULT: begin
                if (bus.clr) begin
                    state_d = SEARCH;
                    good_d  = '0;
                end
            end

            default: begin
                state_d = SEARCH;
                good_d  = '0;
            end
        endcase

        // A fresh error outranks a simultaneous clr.
        if (err_oh_d || err_seq_d) begin
            sticky_d = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= SEARCH;
            good_q    <= '0;
            prev_q    <= '0;
            index_q   <= '0;
            valid_q   <= 1'b0;
            locked_q  <= 1'b0;
            fault_q   <= 1'b0;
            err_oh_q  <= 1'b0;
            err_seq_q <= 1'b0;
            sticky_q  <= 1'b0;
            rot_q     <= '0;
        end else begin
            state_q   <= state_d;
            good_q    <= good_d;
            prev_q    <= prev_d;
            index_q   <= index_d;
            valid_q   <= valid_d;
            locked_q  <= (state_d == LOCKED);
            fault_q   <= (state_d == FAULT);
            err_oh_q  <= err_oh_d;
            err_seq_q <= err_seq_d;
            sticky_q  <= sticky_d;
            rot_q     <= rot_d;
        end
    end

    assign bus.index      = index_q;
    assign bus.valid      = valid_q;
    assign bus.locked     = locked_q;
    assign bus.fault      = fault_q;
    assign bus.err_onehot = err_oh_q;
    assign bus.err_seq    = err_seq_q;
    assign bus.err_sticky = sticky_q;
    assign bus.rot_count  = rot_q;

endmodule

// File: tb/tb_ring_counter_checker.sv
// Directed bench for ring_counter_checker (WIDTH=4, LOCK_CNT=2, CNT_W=8).
// Latency: inputs driven 1 time unit after a rising edge, outputs checked
// 1 time unit after the following rising edge.
module tb_ring_counter_checker;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_fail;

    ring_counter_checker_if #(.WIDTH(4), .CNT_W(8)) bus ();

    ring_counter_checker #(
        .WIDTH    (4),
        .LOCK_CNT (2),
        .CNT_W    (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Check every output against hand-computed values.
    task automatic expect_all(input string tag,
                              input int idx, input int vld, input int lk,
                              input int flt, input int eoh, input int eseq,
                              input int est, input int rot);
        chk({tag, ".index"},      32'(bus.index),      32'(idx));
        chk({tag, ".valid"},      32'(bus.valid),      32'(vld));
        chk({tag, ".locked"},     32'(bus.locked),     32'(lk));
        chk({tag, ".fault"},      32'(bus.fault),      32'(flt));
        chk({tag, ".err_onehot"}, 32'(bus.err_onehot), 32'(eoh));
        chk({tag, ".err_seq"},    32'(bus.err_seq),    32'(eseq));
        chk({tag, ".err_sticky"}, 32'(bus.err_sticky), 32'(est));
        chk({tag, ".rot_count"},  32'(bus.rot_count),  32'(rot));
    endtask

    // Apply one sample and advance past the capturing edge.
    task automatic step(input logic [3:0] ring, input logic c);
        bus.ring_in = ring;
        bus.clr     = c;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_chk       = 0;
        n_fail      = 0;
        rst         = 1'b1;
        bus.ring_in = 4'b0110;
        bus.clr     = 1'b0;

        // Reset held for two edges
        @(posedge clk);
        @(posedge clk);
        #1;
        expect_all("reset", 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        step(4'b0110, 1'b0);
        expect_all("post_reset", 0, 0, 0, 0, 0, 0, 0, 0);

        // Lock and one full rotation
        step(4'b0001, 1'b0); expect_all("lock_e1", 0, 1, 0, 0, 0, 0, 0, 0);
        step(4'b0010, 1'b0); expect_all("lock_e2", 1, 1, 0, 0, 0, 0, 0, 0);
        step(4'b0100, 1'b0); expect_all("lock_e3", 2, 1, 1, 0, 0, 0, 0, 0);
        step(4'b1000, 1'b0); expect_all("lock_e4", 3, 1, 1, 0, 0, 0, 0, 0);
        step(4'b0001, 1'b0); expect_all("lock_e5", 0, 1, 1, 0, 0, 0, 0, 1);

        // Stall while locked
        step(4'b0010, 1'b0); expect_all("stall_pre", 1, 1, 1, 0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            step(4'b0100, 1'b0);
            expect_all("stall_hold", 2, 1, 1, 0, 0, 0, 0, 1);
        end
        step(4'b1000, 1'b0); expect_all("stall_go", 3, 1, 1, 0, 0, 0, 0, 1);

        // Non-one-hot sample while locked
        step(4'b0110, 1'b0); expect_all("oh_err", 3, 0, 0, 1, 1, 0, 1, 1);
        step(4'b0110, 1'b0); expect_all("oh_after", 3, 0, 0, 1, 0, 0, 1, 1);
        step(4'b0001, 1'b1); expect_all("oh_clr", 0, 1, 0, 0, 0, 0, 0, 0);

        // Relock, then an out-of-order one-hot sample
        step(4'b0010, 1'b0); expect_all("seq_e1", 1, 1, 0, 0, 0, 0, 0, 0);
        step(4'b0100, 1'b0); expect_all("seq_e2", 2, 1, 1, 0, 0, 0, 0, 0);
        step(4'b1000, 1'b0); expect_all("seq_e3", 3, 1, 1, 0, 0, 0, 0, 0);
        step(4'b0001, 1'b0); expect_all("seq_e4", 0, 1, 1, 0, 0, 0, 0, 1);
        step(4'b0100, 1'b0); expect_all("seq_err", 2, 1, 0, 1, 0, 1, 1, 1);
        step(4'b0001, 1'b1); expect_all("seq_clr", 0, 1, 0, 0, 0, 0, 0, 0);

        // Error in the same cycle as clr: the error wins
        step(4'b0010, 1'b0); expect_all("race_e1", 1, 1, 0, 0, 0, 0, 0, 0);
        step(4'b0100, 1'b0); expect_all("race_e2", 2, 1, 1, 0, 0, 0, 0, 0);
        step(4'b0001, 1'b1); expect_all("race_err", 0, 1, 0, 1, 0, 1, 1, 0);
        step(4'b0001, 1'b1); expect_all("race_clr", 0, 1, 0, 0, 0, 0, 0, 0);

        // Three rotations, then async reset between edges
        for (int r = 0; r < 3; r++) begin
            step(4'b0010, 1'b0);
            step(4'b0100, 1'b0);
            step(4'b1000, 1'b0);
            step(4'b0001, 1'b0);
        end
        expect_all("rot3", 0, 1, 1, 0, 0, 0, 0, 3);
        #3;
        rst = 1'b1;
        #1;
        expect_all("async_rst", 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Relock needs LOCK_CNT fresh advances after reset
        step(4'b0010, 1'b0); expect_all("relock_e1", 1, 1, 0, 0, 0, 0, 0, 0);
        step(4'b0100, 1'b0); expect_all("relock_e2", 2, 1, 0, 0, 0, 0, 0, 0);
        step(4'b1000, 1'b0); expect_all("relock_e3", 3, 1, 1, 0, 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
